// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR filters of the FM radio chain.
//   QUANT_BITS        - fixed-point fraction bits of samples and coefficients (Q10)
//   DATA_SIZE         - default sample / coefficient width
//   ACC_SIZE          - accumulator width (full signed product width)
//   AUDIO_LPR_COEFFS  - 32-tap symmetric audio low-pass, signed Q10, index 0 first
//   fir_state_t       - controller state encoding
//   deq()             - Q10 dequantisation, truncating toward zero
package fir_pkg;

    localparam int QUANT_BITS     = 10;
    localparam int DATA_SIZE      = 32;
    localparam int ACC_SIZE       = 2 * DATA_SIZE;
    localparam int AUDIO_LPR_TAPS = 32;

    localparam logic signed [DATA_SIZE-1:0] AUDIO_LPR_COEFFS [0:AUDIO_LPR_TAPS-1] = '{
        32'hfffffffd, 32'hfffffffa, 32'hfffffff4, 32'hffffffed,
        32'hffffffe5, 32'hffffffdf, 32'hffffffe2, 32'hfffffff3,
        32'h00000015, 32'h0000004e, 32'h0000009b, 32'h000000f9,
        32'h0000015d, 32'h000001be, 32'h0000020e, 32'h00000243,
        32'h00000243, 32'h0000020e, 32'h000001be, 32'h0000015d,
        32'h000000f9, 32'h0000009b, 32'h0000004e, 32'h00000015,
        32'hfffffff3, 32'hffffffe2, 32'hffffffdf, 32'hffffffe5,
        32'hffffffed, 32'hfffffff4, 32'hfffffffa, 32'hfffffffd
    };

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2
    } fir_state_t;

    // Divide by 2^QUANT_BITS rounding toward zero. An arithmetic shift alone
    // rounds toward minus infinity, so negative values get a bias of
    // 2^QUANT_BITS-1 first.
    function automatic logic signed [ACC_SIZE-1:0] deq(input logic signed [ACC_SIZE-1:0] a);
        logic signed [ACC_SIZE-1:0] biased;
        biased = a[ACC_SIZE-1] ? (a + ACC_SIZE'((1 << QUANT_BITS) - 1)) : a;
        return biased >>> QUANT_BITS;
    endfunction

endpackage

// File: rtl/fir_interp.sv
// fir_interp: polyphase interpolating FIR. Pops one sample from an upstream
// FWFT FIFO and pushes INTERP filtered samples to a downstream FIFO, using a
// single shared multiplier and a sequential multiply-accumulate of
// K = TAPS/INTERP taps per output phase.
//
// Handshake: a transfer happens in exactly the cycle its enable is high.
// in_rd_en is high only when the controller is waiting for input and
// in_empty is low; in_dout is consumed in that same cycle. out_wr_en is high
// only when a result is pending and out_full is low; out_din is valid then.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-low
//   in_empty   upstream FIFO empty
//   in_rd_en   pop upstream FIFO
//   in_dout    signed Q10 input sample
//   out_full   downstream FIFO full
//   out_wr_en  push downstream FIFO
//   out_din    signed Q10 output sample (registered)
//
// TAPS must be a multiple of INTERP.
module fir_interp #(
    parameter int TAPS      = 32,
    parameter int INTERP    = 8,
    parameter int DATA_SIZE = 32,
    parameter logic signed [DATA_SIZE-1:0] COEFFS [0:TAPS-1] = fir_pkg::AUDIO_LPR_COEFFS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_empty,
    output logic                        in_rd_en,
    input  logic signed [DATA_SIZE-1:0] in_dout,
    input  logic                        out_full,
    output logic                        out_wr_en,
    output logic signed [DATA_SIZE-1:0] out_din
);

    import fir_pkg::fir_state_t;
    import fir_pkg::S_READ;
    import fir_pkg::S_MAC;
    import fir_pkg::S_WRITE;
    import fir_pkg::deq;

    localparam int K     = TAPS / INTERP;
    localparam int J_W   = (K > 1) ? $clog2(K) : 1;
    localparam int P_W   = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam int C_W   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int ACC_W = 2 * DATA_SIZE;

    localparam logic [J_W-1:0] J_LAST = J_W'(K - 1);
    localparam logic [P_W-1:0] P_LAST = P_W'(INTERP - 1);

    fir_state_t                  state;
    logic [J_W-1:0]              j;
    logic [P_W-1:0]              p;
    logic signed [ACC_W-1:0]     acc;
    logic signed [DATA_SIZE-1:0] x [0:K-1];

    logic [C_W-1:0]              coef_idx;
    logic signed [DATA_SIZE-1:0] coef;
    logic signed [DATA_SIZE-1:0] x_tap;
    logic signed [ACC_W-1:0]     prod;
    logic signed [ACC_W-1:0]     acc_next;

    // Phase p of the output uses every INTERP-th coefficient starting at p,
    // paired with history tap j.
    assign coef_idx = C_W'(int'(j) * INTERP + int'(p));
    assign coef     = COEFFS[coef_idx];
    assign x_tap    = x[j];
    assign prod     = ACC_W'(coef) * ACC_W'(x_tap);
    assign acc_next = acc + prod;

    assign in_rd_en  = (state == S_READ)  && !in_empty;
    assign out_wr_en = (state == S_WRITE) && !out_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_READ;
            j       <= '0;
            p       <= '0;
            acc     <= '0;
            out_din <= '0;
            for (int i = 0; i < K; i++) begin
                x[i] <= '0;
            end
        end else begin
            case (state)
                S_READ: begin
                    if (!in_empty) begin
                        x[0] <= in_dout;
                        for (int i = 1; i < K; i++) begin
                            x[i] <= x[i-1];
                        end
                        acc   <= '0;
                        p     <= '0;
                        j     <= '0;
                        state <= S_MAC;
                    end
                end

                S_MAC: begin
                    acc <= acc_next;
                    if (j == J_LAST) begin
                        // Result is registered on the last tap so out_din is
                        // already valid in the first S_WRITE cycle.
                        out_din <= DATA_SIZE'(deq(acc_next));
                        state   <= S_WRITE;
                    end else begin
                        j <= j + 1'b1;
                    end
                end

                S_WRITE: begin
                    // While out_full is high everything holds, including out_din.
                    if (!out_full) begin
                        if (p == P_LAST) begin
                            state <= S_READ;
                        end else begin
                            p     <= p + 1'b1;
                            j     <= '0;
                            acc   <= '0;
                            state <= S_MAC;
                        end
                    end
                end

                default: state <= S_READ;
            endcase
        end
    end

endmodule
